// File: rtl/mdu_hilo_pkg.sv
// Shared MDU/ALU decode: operation codes and the MDU state encoding.
package mdu_hilo_pkg;

  localparam logic [5:0] OP_MULT  = 6'd4;
  localparam logic [5:0] OP_MULTU = 6'd5;
  localparam logic [5:0] OP_MADD  = 6'd6;
  localparam logic [5:0] OP_MSUB  = 6'd7;
  localparam logic [5:0] OP_MTHI  = 6'd32;
  localparam logic [5:0] OP_MTLO  = 6'd33;
  localparam logic [5:0] OP_MFHI  = 6'd34;
  localparam logic [5:0] OP_MFLO  = 6'd35;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

  // Codes that start an iterative multiply
  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Every code the HI/LO unit responds to (used for the stall decode)
  function automatic logic is_mdu_op(input logic [5:0] op);
    return is_mul_op(op) || (op == OP_MTHI) || (op == OP_MTLO) ||
           (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/mdu_seq_mult.sv
// Radix-2 shift-add multiplier on unsigned magnitudes, one multiplier bit per step.
module mdu_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_i,
  input  logic                       step_i,
  input  logic [$clog2(WIDTH)-1:0]   cnt_i,
  input  logic [WIDTH-1:0]           a_mag_i,
  input  logic [WIDTH-1:0]           b_mag_i,
  output logic [2*WIDTH-1:0]         prod_o,
  output logic                       last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               last_q;

  // Load magnitudes on accept, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      last_q   <= 1'b0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_mag_i};
      mplier_q <= b_mag_i;
      last_q   <= 1'b0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      last_q   <= (cnt_i == CW'(WIDTH - 1));
    end
  end

  assign prod_o = acc_q;
  assign last_o = last_q;

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: sequential multiply/accumulate plus MTHI/MTLO/MFHI/MFLO.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [5:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] MFResult,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [5:0]         op_q;
  logic               sgn_q;
  logic               a_neg_q;
  logic               b_neg_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               accept;
  logic               sgn_d;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic               last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] hilo_d;

  // Magnitudes are taken from the live operands on the accept edge; the
  // sub-module keeps them, so later A/B changes cannot disturb the multiply.
  assign accept = (state_q == ST_IDLE) && Start && is_mul_op(ALUControl);
  assign sgn_d  = (ALUControl != OP_MULTU);
  assign a_mag  = (sgn_d && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag  = (sgn_d && B[WIDTH-1]) ? (~B + 1'b1) : B;

  mdu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .load_i  (accept),
    .step_i  ((state_q == ST_MUL) && !last),
    .cnt_i   (cnt_q),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .prod_o  (prod),
    .last_o  (last)
  );

  // Sign fix of the magnitude product, then set/accumulate against current HI/LO
  always_comb begin
    prod_fix = prod;
    if (sgn_q && (a_neg_q ^ b_neg_q)) begin
      prod_fix = ~prod + 1'b1;
    end
    case (op_q)
      OP_MADD: hilo_d = {hi_q, lo_q} + prod_fix;
      OP_MSUB: hilo_d = {hi_q, lo_q} - prod_fix;
      default: hilo_d = prod_fix;
    endcase
  end

  // Control FSM with HI/LO writes and the registered Done pulse
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_MUL;
            cnt_q   <= '0;
            op_q    <= ALUControl;
            sgn_q   <= sgn_d;
            a_neg_q <= A[WIDTH-1];
            b_neg_q <= B[WIDTH-1];
          end else if (Start && (ALUControl == OP_MTHI)) begin
            hi_q <= A;
          end else if (Start && (ALUControl == OP_MTLO)) begin
            lo_q <= A;
          end
        end
        ST_MUL: begin
          // The product is complete one cycle after the final step
          if (last) begin
            state_q <= ST_FIN;
          end else if (cnt_q != CW'(WIDTH - 1)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIN: begin
          hi_q    <= hilo_d[2*WIDTH-1:WIDTH];
          lo_q    <= hilo_d[WIDTH-1:0];
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Move-from read port, decoded straight from the current instruction
  always_comb begin
    case (ALUControl)
      OP_MFHI: MFResult = hi_q;
      OP_MFLO: MFResult = lo_q;
      default: MFResult = '0;
    endcase
  end

  assign Busy  = (state_q != ST_IDLE);
  assign Stall = Busy && Start && is_mdu_op(ALUControl);
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: multiply variants, accumulate, stall, move-from and reset abort.
module tb_mdu_hilo;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [5:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic [31:0] MFResult;
  logic        Stall;

  int n_vec = 0;
  int n_err = 0;

  mdu_hilo #(.WIDTH(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Done       (Done),
    .Hi         (Hi),
    .Lo         (Lo),
    .MFResult   (MFResult),
    .Stall      (Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single edge; returns at the negedge after it
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    ALUControl = op;
    A = a;
    B = b;
    @(negedge Clk);
    Start = 1'b0;
    ALUControl = 6'd0;
  endtask

  // Count negedges until Done is seen, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!Done && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic run_mul(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    issue(op, a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd34);
    chk({tag, "_hi"}, {32'd0, Hi}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, Lo}, {32'd0, elo});
  endtask

  initial begin
    int lat;
    bit seen_done;
    Reset = 1'b0;
    Start = 1'b0;
    ALUControl = 6'd0;
    A = '0;
    B = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;

    // Reset state
    ALUControl = 6'd34;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    chk("rst_stall", {63'd0, Stall}, 64'd0);
    chk("rst_mfhi", {32'd0, MFResult}, 64'd0);
    ALUControl = 6'd0;

    // Signed multiply with negative operand, then Done is a single-cycle pulse
    run_mul("mult_neg", 6'd4, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(negedge Clk);
    chk("done_pulse", {63'd0, Done}, 64'd0);
    chk("busy_after", {63'd0, Busy}, 64'd0);

    run_mul("multu_max", 6'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mul("mult_min", 6'd4, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // MTHI/MTLO then accumulate and subtract
    issue(6'd32, 32'd0, 32'd0);
    issue(6'd33, 32'h10, 32'd0);
    chk("mt_hilo", {Hi, Lo}, 64'h0000_0000_0000_0010);
    chk("mt_nodone", {63'd0, Done}, 64'd0);
    run_mul("madd", 6'd6, 32'd2, 32'd3, 32'd0, 32'h16);
    run_mul("msub", 6'd7, 32'd1, 32'h17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // MTLO arriving mid-multiply stalls and is dropped; A change does not disturb the op
    issue(6'd4, 32'd7, 32'd9);
    repeat (5) @(negedge Clk);
    Start = 1'b1;
    ALUControl = 6'd33;
    A = 32'h1234;
    #1;
    chk("mtlo_stall", {63'd0, Stall}, 64'd1);
    @(negedge Clk);
    chk("mtlo_ignored", {32'd0, Lo}, 64'hFFFF_FFFF);
    Start = 1'b0;
    ALUControl = 6'd0;
    wait_done(lat);
    chk("mtlo_mul_done", {63'd0, Done}, 64'd1);
    chk("mtlo_mul_lo", {Hi, Lo}, 64'd63);

    // MFLO while busy reads the old Lo, then the new one after Done
    issue(6'd5, 32'h10, 32'h10);
    Start = 1'b1;
    ALUControl = 6'd0;
    #1;
    chk("nonmdu_nostall", {63'd0, Stall}, 64'd0);
    ALUControl = 6'd35;
    #1;
    chk("mflo_stall", {63'd0, Stall}, 64'd1);
    chk("mflo_old", {32'd0, MFResult}, 64'd63);
    wait_done(lat);
    chk("mflo_lat", 64'(lat), 64'd34);
    chk("mflo_new", {32'd0, MFResult}, 64'h100);
    chk("mflo_nostall", {63'd0, Stall}, 64'd0);
    Start = 1'b0;
    ALUControl = 6'd0;
    @(negedge Clk);

    // Reset in the middle of a multiply aborts it
    issue(6'd32, 32'hAAAA, 32'd0);
    issue(6'd33, 32'h5555, 32'd0);
    chk("preload", {Hi, Lo}, 64'h0000_AAAA_0000_5555);
    issue(6'd4, 32'd3, 32'd3);
    repeat (10) @(negedge Clk);
    chk("abort_busy_pre", {63'd0, Busy}, 64'd1);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    chk("abort_hilo", {Hi, Lo}, 64'd0);
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) seen_done = 1'b1;
      @(negedge Clk);
    end
    chk("abort_nodone", {63'd0, seen_done}, 64'd0);
    chk("abort_hilo_late", {Hi, Lo}, 64'd0);

    // New op accepted directly after reset release
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    run_mul("post_rst", 6'd5, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
